// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory port, branch redirect from
// execute, and the valid/ready instruction slot handed to decode.
interface fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  modport master (
    output imem_addr,
    input  imem_data,
    input  branch_valid,
    input  branch_target,
    output if_valid,
    input  if_ready,
    output if_instr,
    output if_pc
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output branch_valid,
    output branch_target,
    input  if_valid,
    output if_ready,
    input  if_instr,
    input  if_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-slot instruction fetch stage: combinational imem lookup at the PC,
// registered output slot with valid/ready handshake and branch redirect.
module fetch_unit #(
  parameter int PROG_LEN = 11,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  fetch_unit_if.master     io_bus,
  output logic             o_done,
  output logic [CNT_W-1:0] o_fetch_count
);

  localparam logic [31:0] LP_PROG_LEN = 32'(PROG_LEN);
  localparam logic [1:0]  ST_RUN      = 2'd0;
  localparam logic [1:0]  ST_DRAIN    = 2'd1;
  localparam logic [1:0]  ST_DONE     = 2'd2;

  logic [31:0]      r_pc;
  logic             r_if_valid;
  logic [31:0]      r_if_instr;
  logic [31:0]      r_if_pc;
  logic [CNT_W-1:0] r_fetch_count;

  logic       w_transfer;
  logic       w_slot_free;
  logic       w_in_prog;
  logic       w_cnt_full;
  logic [1:0] w_state;

  assign w_transfer  = r_if_valid & io_bus.if_ready;
  assign w_slot_free = ~r_if_valid | w_transfer;
  assign w_in_prog   = (r_pc < LP_PROG_LEN);
  assign w_cnt_full  = (r_fetch_count == {CNT_W{1'b1}});

  // Phase of the stage is fully implied by PC range and slot occupancy.
  always_comb begin
    w_state = ST_RUN;
    if (!w_in_prog) begin
      w_state = r_if_valid ? ST_DRAIN : ST_DONE;
    end
  end

  // Branch wins over fetch and stall; a transfer in the branch cycle is
  // still counted below because the count block looks only at the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= 32'd0;
      r_if_valid <= 1'b0;
      r_if_instr <= 32'd0;
      r_if_pc    <= 32'd0;
    end else if (io_bus.branch_valid) begin
      r_pc       <= io_bus.branch_target;
      r_if_valid <= 1'b0;
    end else if (w_slot_free) begin
      if (w_in_prog) begin
        r_if_instr <= io_bus.imem_data;
        r_if_pc    <= r_pc;
        r_if_valid <= 1'b1;
        r_pc       <= r_pc + 32'd1;
      end else begin
        r_if_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_count <= '0;
    end else if (w_transfer && !w_cnt_full) begin
      r_fetch_count <= r_fetch_count + CNT_W'(1);
    end
  end

  assign io_bus.imem_addr = r_pc;
  assign io_bus.if_valid  = r_if_valid;
  assign io_bus.if_instr  = r_if_instr;
  assign io_bus.if_pc     = r_if_pc;
  assign o_done           = (w_state == ST_DONE);
  assign o_fetch_count    = r_fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a scoreboard of expected fetch PCs is
// popped on every observed handshake, plus per-scenario inline checks.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        done;
  logic [15:0] fetchCount;
  logic        done2;
  logic [2:0]  fetchCount2;

  int checks;
  int errors;
  int expCount;
  logic [31:0] expQ[$];
  logic [31:0] sbPc;

  fetch_unit_if bus ();
  fetch_unit_if bus2 ();

  fetch_unit #(.PROG_LEN(11), .CNT_W(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .io_bus(bus),
    .o_done(done),
    .o_fetch_count(fetchCount)
  );

  // Narrow counter copy, always ready, used to exercise counter saturation.
  fetch_unit #(.PROG_LEN(11), .CNT_W(3)) dut2 (
    .clk(clk),
    .rst_n(rst_n),
    .io_bus(bus2),
    .o_done(done2),
    .o_fetch_count(fetchCount2)
  );

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return 32'hC0DE_0000 ^ (a * 32'h0001_0101);
  endfunction

  assign bus.imem_data      = memWord(bus.imem_addr);
  assign bus2.imem_data     = memWord(bus2.imem_addr);
  assign bus2.if_ready      = 1'b1;
  assign bus2.branch_valid  = 1'b0;
  assign bus2.branch_target = 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.if_valid === 1'b1 && bus.if_ready === 1'b1) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL sb_unexpected: transfer of if_pc=%0d, required no transfer", bus.if_pc);
      end else begin
        sbPc = expQ.pop_front();
        if (bus.if_pc !== sbPc || bus.if_instr !== memWord(sbPc)) begin
          errors++;
          $display("[TB] FAIL sb_transfer: got pc=%0d instr=%h, required pc=%0d instr=%h",
                   bus.if_pc, bus.if_instr, sbPc, memWord(sbPc));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.branch_valid = 1'b0;
    bus.branch_target = 32'd0;
    bus.if_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.if_valid !== 1'b0 || bus.if_pc !== 32'd0 || bus.if_instr !== 32'd0 ||
        fetchCount !== 16'd0 || bus.imem_addr !== 32'd0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: valid=%b pc=%0d instr=%h cnt=%0d addr=%0d done=%b, required all zero",
               bus.if_valid, bus.if_pc, bus.if_instr, fetchCount, bus.imem_addr, done);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'd0 || bus.if_instr !== memWord(0) ||
        bus.imem_addr !== 32'd1 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL first_fetch: valid=%b pc=%0d instr=%h addr=%0d done=%b, required 1/0/%h/1/0",
               bus.if_valid, bus.if_pc, bus.if_instr, bus.imem_addr, done, memWord(0));
    end
  endtask

  task automatic test_straight_run();
    bus.if_ready = 1'b1;
    for (int i = 0; i < 11; i++) expQ.push_back(32'(i));
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      checks++;
      if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'(i) || fetchCount !== 16'(expCount)) begin
        errors++;
        $display("[TB] FAIL run_seq: valid=%b pc=%0d cnt=%0d, required 1/%0d/%0d",
                 bus.if_valid, bus.if_pc, fetchCount, i, expCount);
      end
      tick();
      expCount++;
    end
    checks++;
    if (done !== 1'b1 || bus.if_valid !== 1'b0 || fetchCount !== 16'd11 || bus.imem_addr !== 32'd11) begin
      errors++;
      $display("[TB] FAIL run_end: done=%b valid=%b cnt=%0d addr=%0d, required 1/0/11/11",
               done, bus.if_valid, fetchCount, bus.imem_addr);
    end
  endtask

  task automatic test_saturation();
    checks++;
    if (fetchCount2 !== 3'd7 || done2 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL cnt_saturate: cnt=%0d done=%b, required 7/1", fetchCount2, done2);
    end
  endtask

  task automatic test_stall();
    bus.branch_valid = 1'b1;
    bus.branch_target = 32'd0;
    tick();
    bus.branch_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.if_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL restart_bubble: valid=%b done=%b, required 0/0", bus.if_valid, done);
    end
    tick();
    expQ.push_back(32'd0);
    expQ.push_back(32'd1);
    tick();
    tick();
    expCount += 2;
    bus.if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'd2 || bus.if_instr !== memWord(2) ||
          bus.imem_addr !== 32'd3 || fetchCount !== 16'(expCount)) begin
        errors++;
        $display("[TB] FAIL stall_hold: valid=%b pc=%0d instr=%h addr=%0d cnt=%0d, required 1/2/%h/3/%0d",
                 bus.if_valid, bus.if_pc, bus.if_instr, bus.imem_addr, fetchCount, memWord(2), expCount);
      end
      tick();
    end
    bus.if_ready = 1'b1;
    expQ.push_back(32'd2);
    expQ.push_back(32'd3);
    tick();
    expCount++;
    @(negedge clk);
    checks++;
    if (bus.if_pc !== 32'd3 || bus.if_valid !== 1'b1 || fetchCount !== 16'(expCount)) begin
      errors++;
      $display("[TB] FAIL stall_resume: pc=%0d valid=%b cnt=%0d, required 3/1/%0d",
               bus.if_pc, bus.if_valid, fetchCount, expCount);
    end
    tick();
    expCount++;
  endtask

  task automatic test_branch_stall();
    bus.if_ready = 1'b0;
    bus.branch_valid = 1'b1;
    bus.branch_target = 32'd8;
    @(negedge clk);
    checks++;
    if (bus.if_pc !== 32'd4 || bus.if_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL br_pre: pc=%0d valid=%b, required 4/1", bus.if_pc, bus.if_valid);
    end
    tick();
    bus.branch_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.if_valid !== 1'b0 || bus.imem_addr !== 32'd8) begin
      errors++;
      $display("[TB] FAIL br_flush: valid=%b addr=%0d, required 0/8", bus.if_valid, bus.imem_addr);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'd8 || bus.if_instr !== memWord(8) ||
        fetchCount !== 16'(expCount)) begin
      errors++;
      $display("[TB] FAIL br_target: valid=%b pc=%0d instr=%h cnt=%0d, required 1/8/%h/%0d",
               bus.if_valid, bus.if_pc, bus.if_instr, fetchCount, memWord(8), expCount);
    end
    tick();
  endtask

  task automatic test_branch_transfer();
    bus.branch_valid = 1'b1;
    bus.branch_target = 32'd5;
    tick();
    bus.branch_valid = 1'b0;
    tick();
    bus.if_ready = 1'b1;
    bus.branch_valid = 1'b1;
    bus.branch_target = 32'd1;
    expQ.push_back(32'd5);
    @(negedge clk);
    checks++;
    if (bus.if_pc !== 32'd5 || bus.if_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL brx_pre: pc=%0d valid=%b, required 5/1", bus.if_pc, bus.if_valid);
    end
    tick();
    expCount++;
    bus.branch_valid = 1'b0;
    bus.if_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.if_valid !== 1'b0 || fetchCount !== 16'(expCount)) begin
      errors++;
      $display("[TB] FAIL brx_count: valid=%b cnt=%0d, required 0/%0d", bus.if_valid, fetchCount, expCount);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'd1 || bus.if_instr !== memWord(1)) begin
      errors++;
      $display("[TB] FAIL brx_target: valid=%b pc=%0d instr=%h, required 1/1/%h",
               bus.if_valid, bus.if_pc, bus.if_instr, memWord(1));
    end
    tick();
  endtask

  task automatic test_out_of_range();
    bus.branch_valid = 1'b1;
    bus.branch_target = 32'd20;
    tick();
    bus.branch_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || bus.if_valid !== 1'b0 || bus.imem_addr !== 32'd20) begin
        errors++;
        $display("[TB] FAIL oor_done: done=%b valid=%b addr=%0d, required 1/0/20",
                 done, bus.if_valid, bus.imem_addr);
      end
      tick();
    end
    bus.branch_valid = 1'b1;
    bus.branch_target = 32'd0;
    tick();
    bus.branch_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || bus.if_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL oor_return: done=%b valid=%b, required 0/0", done, bus.if_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'd0 || fetchCount !== 16'(expCount)) begin
      errors++;
      $display("[TB] FAIL oor_refetch: valid=%b pc=%0d cnt=%0d, required 1/0/%0d",
               bus.if_valid, bus.if_pc, fetchCount, expCount);
    end
    tick();
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.if_valid !== 1'b0 || bus.if_pc !== 32'd0 || bus.if_instr !== 32'd0 ||
        fetchCount !== 16'd0 || bus.imem_addr !== 32'd0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_clear: valid=%b pc=%0d instr=%h cnt=%0d addr=%0d done=%b, required all zero",
               bus.if_valid, bus.if_pc, bus.if_instr, fetchCount, bus.imem_addr, done);
    end
    expQ.delete();
    expCount = 0;
    tick();
    rst_n = 1'b1;
    bus.if_ready = 1'b1;
    for (int i = 0; i < 3; i++) expQ.push_back(32'(i));
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'(i) || fetchCount !== 16'(expCount)) begin
        errors++;
        $display("[TB] FAIL async_restart: valid=%b pc=%0d cnt=%0d, required 1/%0d/%0d",
                 bus.if_valid, bus.if_pc, fetchCount, i, expCount);
      end
      tick();
      expCount++;
    end
    bus.if_ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    expCount = 0;
    test_reset();
    test_straight_run();
    test_saturation();
    test_stall();
    test_branch_stall();
    test_branch_transfer();
    test_out_of_range();
    test_async_reset();
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_drain: %0d expected transfers left, required 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] time limit");
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PROG_LEN, default 11: number of valid instruction words; word indices PROG_LEN and above are out of program.
REQ-002 Parameter CNT_W, default 16: width of fetch_count.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 imem_addr  output  32  word index presented to instruction memory; equals the PC register combinationally.
REQ-006 imem_data  input  32  instruction word returned combinationally for imem_addr.
REQ-007 branch_valid  input  1  redirect request from execute.
REQ-008 branch_target  input  32  word index to redirect to; sampled only when branch_valid=1.
REQ-009 if_valid  output  1  if_instr/if_pc hold an instruction for decode.
REQ-010 if_ready  input  1  decode accepts the instruction this cycle.
REQ-011 if_instr  output  32  registered instruction word.
REQ-012 if_pc  output  32  word index if_instr was fetched from.
REQ-013 done  output  1  PC is out of program and the output slot is empty.
REQ-014 fetch_count  output  CNT_W  number of completed if_valid/if_ready handshakes.

Function
REQ-015 Handshake: transfer occurs in a cycle with if_valid=1 and if_ready=1; if_instr/if_pc/if_valid SHALL stay stable while if_valid=1 and if_ready=0.
REQ-016 Slot free = (if_valid=0) or transfer this cycle.
REQ-017 Fetch condition: slot free, branch_valid=0, PC < PROG_LEN (unsigned compare).
REQ-018 On fetch: if_instr<=imem_data, if_pc<=PC, if_valid<=1, PC<=PC+1 (32-bit, no wrap check beyond compare).
REQ-019 Slot free, branch_valid=0, PC >= PROG_LEN: if_valid<=0; PC unchanged.
REQ-020 branch_valid=1: PC<=branch_target, if_valid<=0 next cycle (flush), no fetch that cycle; branch has priority over fetch and stall.
REQ-021 A transfer coinciding with branch_valid=1 SHALL complete and be counted; the flushed slot is discarded only when no transfer occurs.
REQ-022 First instruction at the redirected target SHALL appear with if_valid=1 two cycles after the branch_valid cycle (one flush bubble).
REQ-023 branch_target >= PROG_LEN: no further fetch; done asserts the cycle after the branch.
REQ-024 Sustained throughput: one instruction per cycle while if_ready=1 and no branch.
REQ-025 Internal states: RUN (PC < PROG_LEN), DRAIN (PC >= PROG_LEN, if_valid=1), DONE (PC >= PROG_LEN, if_valid=0); a branch with in-range target SHALL return DONE/DRAIN to RUN.
REQ-026 done = 1 exactly in state DONE; derived from registers only.
REQ-027 fetch_count increments by 1 per transfer, saturates at all-ones, never wraps.
REQ-028 imem_data is not registered elsewhere; fetch latency from PC change to if_valid is one cycle.

Reset
REQ-029 rst_n=0 SHALL immediately force PC=0, if_valid=0, if_instr=0, if_pc=0, fetch_count=0, regardless of clk.
REQ-030 done=0 during and after reset when PROG_LEN>0; first fetch of word 0 on the first rising edge with rst_n=1, if_valid=1 after it.
REQ-031 Reset asserted mid-stall or mid-branch SHALL discard the pending instruction and redirect without any transfer being counted.

Verification
REQ-032 Straight run, PROG_LEN=11, if_ready=1: if_pc sequence 0..10 on consecutive cycles, if_instr matches memory words, fetch_count=11, done=1 the cycle after if_pc=10 transfers.
REQ-033 Stall: if_ready=0 for 3 cycles while if_pc=2 -> if_instr/if_pc held at word 2, imem_addr stays 3, fetch_count unchanged; resumes with if_pc=3 after release.
REQ-034 Branch: branch_valid=1, target=8 while if_pc=4 valid and if_ready=0 -> next cycle if_valid=0, following cycle if_pc=8; word 4 not counted.
REQ-035 Branch with transfer: if_pc=5 transfers in the branch_valid cycle, target=1 -> fetch_count +1, then if_pc=1 after one bubble.
REQ-036 Out-of-range: branch target=20 -> done=1 next cycle, if_valid stays 0; later branch target=0 -> done=0, if_pc=0 two cycles later.
REQ-037 Async reset: drop rst_n between clock edges during stall -> outputs clear immediately; after release sequence restarts at if_pc=0, fetch_count=0.
